// File: rtl/button_repeat_conditioner.sv
// Multi-channel switch conditioner: 2-flop sync, per-channel debounce, press/repeat/release pulses.
// Level latency 2+DEBOUNCE_TICKS cycles; pulses coincide with level edges; no backpressure (free-running).
module button_repeat_conditioner #(
  parameter int WIDTH          = 6,
  parameter int DEBOUNCE_TICKS = 200,
  parameter int REPEAT_DELAY   = 5000,
  parameter int REPEAT_PERIOD  = 1000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_press_pulse,
  output logic [WIDTH-1:0] o_release_pulse,
  output logic             o_any_press
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_DELAY  = 2'd1;
  localparam logic [1:0]  ST_REPEAT = 2'd2;
  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_TICKS - 1);
  localparam logic [15:0] RD_LAST   = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RP_LAST   = 16'(REPEAT_PERIOD - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_press_nxt;
  logic             r_any_press;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_any_press <= 1'b0;
    end else begin
      r_s1        <= i_raw;
      r_s2        <= r_s1;
      r_any_press <= |w_press_nxt;
    end
  end

  assign o_any_press = r_any_press;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [15:0] r_db_cnt;
    logic [15:0] r_rep_cnt;
    logic [1:0]  r_state;
    logic        r_level;
    logic        r_press;
    logic        r_release;
    logic        w_toggle;
    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_rep_inc;
    logic [15:0] w_rep_nxt;
    logic [1:0]  w_state_nxt;
    logic        w_press;
    logic        w_release;

    assign w_toggle  = (r_s2[g] != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise    = w_toggle && !r_level;
    assign w_fall    = w_toggle && r_level;
    assign w_rep_inc = (r_rep_cnt == 16'hFFFF) ? r_rep_cnt : r_rep_cnt + 16'd1;

    // A falling level always wins over a repeat tick landing on the same edge.
    always_comb begin
      w_state_nxt = r_state;
      w_rep_nxt   = w_rep_inc;
      w_press     = 1'b0;
      w_release   = 1'b0;
      if (!i_enable) begin
        w_state_nxt = ST_IDLE;
        w_rep_nxt   = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_rep_nxt = '0;
            if (w_rise) begin
              w_state_nxt = ST_DELAY;
              w_press     = 1'b1;
            end
          end
          ST_DELAY: begin
            if (w_fall) begin
              w_state_nxt = ST_IDLE;
              w_rep_nxt   = '0;
              w_release   = 1'b1;
            end else if (r_rep_cnt == RD_LAST) begin
              w_state_nxt = ST_REPEAT;
              w_rep_nxt   = '0;
              w_press     = 1'b1;
            end
          end
          ST_REPEAT: begin
            if (w_fall) begin
              w_state_nxt = ST_IDLE;
              w_rep_nxt   = '0;
              w_release   = 1'b1;
            end else if (r_rep_cnt == RP_LAST) begin
              w_rep_nxt = '0;
              w_press   = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rep_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        r_db_cnt  <= '0;
        r_rep_cnt <= '0;
        r_state   <= ST_IDLE;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        if (r_s2[g] == r_level) begin
          r_db_cnt <= '0;
        end else if (w_toggle) begin
          r_db_cnt <= '0;
          r_level  <= ~r_level;
        end else begin
          r_db_cnt <= r_db_cnt + 16'd1;
        end
        r_rep_cnt <= w_rep_nxt;
        r_state   <= w_state_nxt;
        r_press   <= w_press;
        r_release <= w_release;
      end
    end

    assign w_press_nxt[g]     = w_press;
    assign o_level[g]         = r_level;
    assign o_press_pulse[g]   = r_press;
    assign o_release_pulse[g] = r_release;
  end

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Bench for button_repeat_conditioner with short debounce/repeat parameters.
module tb_button_repeat_conditioner;

  logic       clock;
  logic       rst;
  logic [5:0] i_raw;
  logic       i_enable;
  logic [5:0] o_level;
  logic [5:0] o_press_pulse;
  logic [5:0] o_release_pulse;
  logic       o_any_press;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  typedef struct {
    int         cyc;
    logic [5:0] press;
    logic [5:0] rel;
  } ev_t;

  ev_t exp_q[$];

  button_repeat_conditioner #(
    .WIDTH(6), .DEBOUNCE_TICKS(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clock(clock),
    .rst(rst),
    .i_raw(i_raw),
    .i_enable(i_enable),
    .o_level(o_level),
    .o_press_pulse(o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_any_press(o_any_press)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  function automatic void exp_ev(int c, logic [5:0] p, logic [5:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    i_raw = 6'b111111;
    repeat (3) step();
    vectors++;
    if ({o_level, o_press_pulse, o_release_pulse, o_any_press} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got lvl=%b p=%b r=%b a=%b, want all 0",
               o_level, o_press_pulse, o_release_pulse, o_any_press);
    end
    i_raw = '0;
    repeat (3) step();
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      vectors++;
      if ({o_level, o_press_pulse, o_release_pulse, o_any_press} !== 19'd0) begin
        miscompares++;
        $display("FAIL reset_release n=%0d: got lvl=%b p=%b r=%b a=%b, want all 0",
                 n, o_level, o_press_pulse, o_release_pulse, o_any_press);
      end
    end
  endtask

  task automatic test_press_repeat();
    int t0;
    ev_t e;
    logic [5:0] ep, er;
    logic exp_lvl;
    t0 = cyc;
    i_raw[0] = 1'b1;
    exp_ev(t0 + 6, 6'b000001, 6'b0);
    for (int k = 0; k < 8; k++) exp_ev(t0 + 26 + 5 * k, 6'b000001, 6'b0);
    exp_ev(t0 + 66, 6'b0, 6'b000001);
    for (int n = 1; n <= 75; n++) begin
      step();
      ep = '0; er = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); ep = e.press; er = e.rel;
      end
      vectors++;
      if ({o_press_pulse, o_release_pulse, o_any_press} !== {ep, er, |ep}) begin
        miscompares++;
        $display("FAIL press_repeat n=%0d: got p=%b r=%b a=%b, want p=%b r=%b a=%b",
                 n, o_press_pulse, o_release_pulse, o_any_press, ep, er, |ep);
      end
      if (n == 5 || n == 6 || n == 65 || n == 66) begin
        exp_lvl = (n >= 6 && n < 66);
        vectors++;
        if (o_level[0] !== exp_lvl) begin
          miscompares++;
          $display("FAIL press_repeat_level n=%0d: got %b want %b", n, o_level[0], exp_lvl);
        end
      end
      if (n == 60) i_raw[0] = 1'b0;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL press_repeat_pending: %0d events not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    i_raw[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      vectors++;
      if ({o_level[1], o_press_pulse, o_release_pulse, o_any_press} !== 14'd0) begin
        miscompares++;
        $display("FAIL glitch n=%0d: got lvl1=%b p=%b r=%b a=%b, want all 0",
                 n, o_level[1], o_press_pulse, o_release_pulse, o_any_press);
      end
      if (n == 3) i_raw[1] = 1'b0;
    end
  endtask

  task automatic test_enable_mask();
    int t0;
    ev_t e;
    logic [5:0] ep, er;
    logic exp_lvl;
    t0 = cyc;
    i_enable = 1'b0;
    i_raw[2] = 1'b1;
    exp_ev(t0 + 66, 6'b000100, 6'b0);
    exp_ev(t0 + 76, 6'b0, 6'b000100);
    for (int n = 1; n <= 85; n++) begin
      step();
      ep = '0; er = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); ep = e.press; er = e.rel;
      end
      vectors++;
      if ({o_press_pulse, o_release_pulse, o_any_press} !== {ep, er, |ep}) begin
        miscompares++;
        $display("FAIL enable_mask n=%0d: got p=%b r=%b a=%b, want p=%b r=%b a=%b",
                 n, o_press_pulse, o_release_pulse, o_any_press, ep, er, |ep);
      end
      if (n == 5 || n == 6 || n == 55 || n == 56 || n == 66) begin
        exp_lvl = (n >= 6 && n < 56) || (n >= 66 && n < 76);
        vectors++;
        if (o_level[2] !== exp_lvl) begin
          miscompares++;
          $display("FAIL enable_mask_level n=%0d: got %b want %b", n, o_level[2], exp_lvl);
        end
      end
      if (n == 40) i_enable = 1'b1;
      if (n == 50) i_raw[2] = 1'b0;
      if (n == 60) i_raw[2] = 1'b1;
      if (n == 70) i_raw[2] = 1'b0;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL enable_mask_pending: %0d events not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_hold();
    int t0;
    ev_t e;
    logic [5:0] ep, er;
    t0 = cyc;
    i_raw[3] = 1'b1;
    exp_ev(t0 + 6,  6'b001000, 6'b0);
    exp_ev(t0 + 26, 6'b001000, 6'b0);
    exp_ev(t0 + 38, 6'b001000, 6'b0);
    exp_ev(t0 + 46, 6'b0, 6'b001000);
    for (int n = 1; n <= 55; n++) begin
      step();
      ep = '0; er = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); ep = e.press; er = e.rel;
      end
      vectors++;
      if ({o_press_pulse, o_release_pulse, o_any_press} !== {ep, er, |ep}) begin
        miscompares++;
        $display("FAIL reset_mid_hold n=%0d: got p=%b r=%b a=%b, want p=%b r=%b a=%b",
                 n, o_press_pulse, o_release_pulse, o_any_press, ep, er, |ep);
      end
      if (n == 30) begin
        rst = 1'b0;
        #1;
        vectors++;
        if ({o_level, o_press_pulse, o_release_pulse, o_any_press} !== 19'd0) begin
          miscompares++;
          $display("FAIL reset_async_clear: got lvl=%b p=%b r=%b a=%b, want all 0",
                   o_level, o_press_pulse, o_release_pulse, o_any_press);
        end
      end
      if (n == 37 || n == 38) begin
        vectors++;
        if (o_level[3] !== (n == 38)) begin
          miscompares++;
          $display("FAIL reset_relevel n=%0d: got %b want %b", n, o_level[3], (n == 38));
        end
      end
      if (n == 32) rst = 1'b1;
      if (n == 40) i_raw[3] = 1'b0;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_hold_pending: %0d events not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    int t0;
    ev_t e;
    logic [5:0] ep, er;
    t0 = cyc;
    i_raw[5:4] = 2'b11;
    exp_ev(t0 + 6,  6'b110000, 6'b0);
    exp_ev(t0 + 26, 6'b110000, 6'b0);
    exp_ev(t0 + 31, 6'b110000, 6'b0);
    exp_ev(t0 + 34, 6'b0, 6'b110000);
    for (int n = 1; n <= 40; n++) begin
      step();
      ep = '0; er = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); ep = e.press; er = e.rel;
      end
      vectors++;
      if ({o_press_pulse, o_release_pulse, o_any_press} !== {ep, er, |ep}) begin
        miscompares++;
        $display("FAIL simultaneous n=%0d: got p=%b r=%b a=%b, want p=%b r=%b a=%b",
                 n, o_press_pulse, o_release_pulse, o_any_press, ep, er, |ep);
      end
      if (n == 28) i_raw[5:4] = 2'b00;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL simultaneous_pending: %0d events not seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    clock    = 1'b0;
    rst      = 1'b0;
    i_raw    = '0;
    i_enable = 1'b1;
    test_reset();
    test_press_repeat();
    test_glitch();
    test_enable_mask();
    test_reset_mid_hold();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_repeat_conditioner.md
BUTTON_REPEAT_CONDITIONER -- requirements
Module: button_repeat_conditioner

Interface
REQ-001 Parameter WIDTH, default 6: number of independent switch/button channels.
REQ-002 Parameter DEBOUNCE_TICKS, default 200: consecutive stable clock cycles required to accept a level change (20 ms at 10 kHz).
REQ-003 Parameter REPEAT_DELAY, default 5000: cycles from accepted press to first auto-repeat pulse (0.5 s at 10 kHz).
REQ-004 Parameter REPEAT_PERIOD, default 1000: cycles between successive auto-repeat pulses (0.1 s at 10 kHz).
REQ-005 clock  input  1  system clock, rising-edge active (nominally the 10 kHz scan clock).
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 raw  input  WIDTH  asynchronous raw switch/button levels.
REQ-008 enable  input  1  1 = press, repeat and release pulses permitted; 0 = pulses masked.
REQ-009 level  output  WIDTH  debounced level per channel.
REQ-010 press_pulse  output  WIDTH  one-cycle pulse per accepted press and per auto-repeat.
REQ-011 release_pulse  output  WIDTH  one-cycle pulse per accepted release.
REQ-012 any_press  output  1  registered OR of the press_pulse bits, coincident with them.

Function
REQ-013 Each raw bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-014 Per channel, a debounce counter SHALL increment each cycle s2 != level; it SHALL clear in any cycle s2 == level.
REQ-015 level SHALL toggle, and the counter SHALL clear, at the edge where the mismatch has been sampled for DEBOUNCE_TICKS consecutive cycles; clean-step latency from raw change to level is 2 + DEBOUNCE_TICKS cycles.
REQ-016 A glitch shorter than DEBOUNCE_TICKS cycles at s2 SHALL leave level unchanged.
REQ-017 Each channel SHALL run a repeat FSM with states IDLE, DELAY, REPEAT and a 16-bit repeat counter.
REQ-018 IDLE -> DELAY on level rising with enable=1; press_pulse SHALL assert in the same cycle level first reads 1; the counter SHALL clear.
REQ-019 In DELAY, once level has been held REPEAT_DELAY cycles after the press, press_pulse SHALL assert for one cycle, the state SHALL become REPEAT and the counter SHALL clear.
REQ-020 In REPEAT, press_pulse SHALL assert for one cycle every REPEAT_PERIOD cycles; pulses fall at t+REPEAT_DELAY+k*REPEAT_PERIOD (k >= 0), where t is the press cycle.
REQ-021 On level falling from DELAY or REPEAT, the state SHALL become IDLE, the counter SHALL clear and release_pulse SHALL assert for one cycle in the cycle level first reads 0.
REQ-022 enable=0 SHALL force every FSM to IDLE and hold press_pulse, release_pulse and any_press at 0; level SHALL continue to track.
REQ-023 A channel already at level=1 when enable rises SHALL produce no pulse until its next accepted rising level.
REQ-024 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-025 Repeat counters SHALL saturate, never wrap; legal parameter range is 1..65535, and 0 is illegal.

Reset
REQ-026 While rst=0: s1, s2, level, all counters = 0; all FSMs IDLE; press_pulse, release_pulse, any_press = 0.
REQ-027 Reset asserted mid-hold SHALL clear state immediately with no release_pulse.
REQ-028 raw held high through reset release SHALL be treated as a new press: level rises 2+DEBOUNCE_TICKS cycles after release, with one press_pulse.

Verification (DEBOUNCE_TICKS=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, enable=1)
REQ-029 raw[0] step 0->1 at cycle 0 -> level[0]=1 and press_pulse[0]=1 at cycle 6 only; any_press=1 at cycle 6.
REQ-030 raw[0] held from cycle 0 to 60 -> press_pulse[0] at cycles 6, 26, 31, 36, 41, 46, 51, 56, 61; release_pulse[0] once at cycle 66; level[0]=0 from cycle 66.
REQ-031 raw[1] 3-cycle high glitch, then low -> level[1], press_pulse[1] and release_pulse[1] stay 0 throughout.
REQ-032 raw[2] held high, enable=0 cycles 0-40, enable=1 afterwards -> level[2]=1 at cycle 6, no pulses at any cycle; a later release and re-press produce a normal press_pulse.
REQ-033 raw[3] held high, rst pulsed low at cycle 30 for 2 cycles -> outputs 0 during reset, no release_pulse, new press_pulse 6 cycles after rst returns high.
REQ-034 raw[4] and raw[5] rise at the same cycle -> identical press_pulse timing on both; any_press single-bit coincident.
